// File: rtl/pcie_status_led.sv
// PCIe link status indicator: saturating error counters, a sticky uncorrectable flag,
// per-error LED pulse stretchers and a free-running heartbeat.

module pcie_status_led_stretch #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic event_i,
  output logic active_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: hold-current defaults come first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (event_i) begin
      state_d = ACTIVE;
      cnt_d   = CW'(CYCLES);
    end else if (state_q == ACTIVE) begin
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // The state register is itself the LED drive, so the output stays glitch-free.
  assign active_o = (state_q == ACTIVE);

endmodule

module pcie_status_led #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned STRETCH_CYCLES = 25000000,
  parameter int unsigned HEARTBEAT_HALF = 125000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   status_error_cor,
  input  logic                   status_error_uncor,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] err_cor_count,
  output logic [COUNT_WIDTH-1:0] err_uncor_count,
  output logic                   err_uncor_sticky,
  output logic [1:0]             user_led_g,
  output logic                   user_led_r,
  output logic [1:0]             front_led
);

  localparam int unsigned PRE_W = $clog2(HEARTBEAT_HALF + 1);

  logic [COUNT_WIDTH-1:0] cor_cnt_q, cor_cnt_d;
  logic [COUNT_WIDTH-1:0] unc_cnt_q, unc_cnt_d;
  logic                   sticky_q, sticky_d;
  logic                   healthy_q, healthy_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic                   hb_q, hb_d;

  // Clear wins over the old value but never swallows a coincident event.
  function automatic logic [COUNT_WIDTH-1:0] count_next(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   ev,
    input logic                   clr
  );
    if (clr) return ev ? COUNT_WIDTH'(1) : '0;
    if (ev && (cnt != '1)) return cnt + COUNT_WIDTH'(1);
    return cnt;
  endfunction

  always_comb begin
    cor_cnt_d = count_next(cor_cnt_q, status_error_cor, clear);
    unc_cnt_d = count_next(unc_cnt_q, status_error_uncor, clear);
    sticky_d  = status_error_uncor | (sticky_q & ~clear);
    healthy_d = ~sticky_d;
    pre_d     = pre_q + PRE_W'(1);
    hb_d      = hb_q;
    if (pre_q == PRE_W'(HEARTBEAT_HALF - 1)) begin
      pre_d = '0;
      hb_d  = ~hb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_cnt_q <= '0;
      unc_cnt_q <= '0;
      sticky_q  <= 1'b0;
      healthy_q <= 1'b1;
      pre_q     <= '0;
      hb_q      <= 1'b0;
    end else begin
      cor_cnt_q <= cor_cnt_d;
      unc_cnt_q <= unc_cnt_d;
      sticky_q  <= sticky_d;
      healthy_q <= healthy_d;
      pre_q     <= pre_d;
      hb_q      <= hb_d;
    end
  end

  pcie_status_led_stretch #(.CYCLES(STRETCH_CYCLES)) u_stretch_cor (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_i  (status_error_cor),
    .active_o (front_led[0])
  );

  pcie_status_led_stretch #(.CYCLES(STRETCH_CYCLES)) u_stretch_uncor (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_i  (status_error_uncor),
    .active_o (front_led[1])
  );

  assign err_cor_count    = cor_cnt_q;
  assign err_uncor_count  = unc_cnt_q;
  assign err_uncor_sticky = sticky_q;
  assign user_led_r       = sticky_q;
  assign user_led_g       = {healthy_q, hb_q};

endmodule

// File: tb/tb_pcie_status_led.sv
// Self-checking bench for pcie_status_led: an event-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_pcie_status_led;

  localparam int CW   = 4;
  localparam int SC   = 4;
  localparam int HH   = 8;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cor, unc, clr;
  logic [CW-1:0] err_cor_count, err_uncor_count;
  logic          err_uncor_sticky;
  logic [1:0]    user_led_g;
  logic          user_led_r;
  logic [1:0]    front_led;

  int n_pass  = 0;
  int n_total = 0;

  pcie_status_led #(
    .COUNT_WIDTH    (CW),
    .STRETCH_CYCLES (SC),
    .HEARTBEAT_HALF (HH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .status_error_cor   (cor),
    .status_error_uncor (unc),
    .clear              (clr),
    .err_cor_count      (err_cor_count),
    .err_uncor_count    (err_uncor_count),
    .err_uncor_sticky   (err_uncor_sticky),
    .user_led_g         (user_led_g),
    .user_led_r         (user_led_r),
    .front_led          (front_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: counts of events, edges since reset, and edge index of the last event per input.
  int m_edge = 0, m_cor = 0, m_unc = 0;
  int last_cor = -1000, last_unc = -1000;
  bit m_sticky = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_cor = 0; m_unc = 0;
      last_cor = -1000; last_unc = -1000;
      m_sticky = 1'b0;
    end else begin
      m_edge++;
      if (clr) begin
        m_cor = cor ? 1 : 0;
        m_unc = unc ? 1 : 0;
      end else begin
        if (cor && m_cor < MAXC) m_cor++;
        if (unc && m_unc < MAXC) m_unc++;
      end
      if (unc) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
      if (cor) last_cor = m_edge;
      if (unc) last_unc = m_edge;
    end
  end

  always @(negedge clk) begin
    logic exp_hb, exp_f0, exp_f1;
    exp_hb = ((m_edge / HH) % 2) == 1;
    exp_f0 = (m_edge - last_cor) < SC;
    exp_f1 = (m_edge - last_unc) < SC;
    check("model_cor_count", err_cor_count, m_cor);
    check("model_uncor_count", err_uncor_count, m_unc);
    check("model_sticky", err_uncor_sticky, m_sticky);
    check("model_led_r", user_led_r, m_sticky);
    check("model_led_g", user_led_g, {~m_sticky, exp_hb});
    check("model_front_led", front_led, {exp_f1, exp_f0});
  end

  task automatic cyc(input logic c, input logic u, input logic k);
    cor = c; unc = u; clr = k;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cor = 1'b0; unc = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cor_count", err_cor_count, 0);
    check("reset_led_g", user_led_g, 2'b10);
    check("reset_front", front_led, 2'b00);
    rst_n = 1'b1;

    // Heartbeat free run: toggles on edges 8 and 16 after release.
    repeat (7) cyc(0, 0, 0);
    check("hb_edge7", user_led_g[0], 0);
    cyc(0, 0, 0);
    check("hb_edge8", user_led_g[0], 1);
    repeat (7) cyc(0, 0, 0);
    check("hb_edge15", user_led_g[0], 1);
    cyc(0, 0, 0);
    check("hb_edge16", user_led_g[0], 0);

    // Three single-cycle correctable pulses.
    cyc(1, 0, 0);
    check("cor_first_front", front_led[0], 1);
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    check("cor_count_3", err_cor_count, 3);
    repeat (3) cyc(0, 0, 0);
    check("cor_front_3_after", front_led[0], 1);
    cyc(0, 0, 0);
    check("cor_front_4_after", front_led[0], 0);

    // Held correctable error saturates.
    repeat (20) cyc(1, 0, 0);
    check("cor_saturated", err_cor_count, 15);
    check("cor_held_front", front_led[0], 1);
    repeat (5) cyc(0, 0, 0);
    check("cor_drained", front_led[0], 0);

    // One uncorrectable pulse, then clear.
    cyc(0, 1, 0);
    check("unc_count_1", err_uncor_count, 1);
    check("unc_sticky", err_uncor_sticky, 1);
    check("unc_led_r", user_led_r, 1);
    check("unc_led_g1", user_led_g[1], 0);
    cyc(0, 0, 1);
    check("clear_unc_count", err_uncor_count, 0);
    check("clear_cor_count", err_cor_count, 0);
    check("clear_sticky", err_uncor_sticky, 0);
    check("clear_front1_kept", front_led[1], 1);
    repeat (2) cyc(0, 0, 0);
    check("unc_front_3_after", front_led[1], 1);
    cyc(0, 0, 0);
    check("unc_front_4_after", front_led[1], 0);

    // Clear coinciding with an uncorrectable event at count 5.
    repeat (5) cyc(0, 1, 0);
    check("unc_count_5", err_uncor_count, 5);
    cyc(0, 1, 1);
    check("clr_evt_count", err_uncor_count, 1);
    check("clr_evt_sticky", err_uncor_sticky, 1);

    // Simultaneous events on both inputs.
    cyc(1, 1, 0);
    check("both_cor", err_cor_count, 1);
    check("both_unc", err_uncor_count, 2);

    // Asynchronous reset between edges with activity in flight.
    cyc(1, 1, 0);
    check("pre_rst_front", front_led, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cor_count", err_cor_count, 0);
    check("arst_unc_count", err_uncor_count, 0);
    check("arst_sticky", err_uncor_sticky, 0);
    check("arst_led_g", user_led_g, 2'b10);
    check("arst_led_r", user_led_r, 0);
    check("arst_front", front_led, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0);
    check("post_rst_first_event", err_cor_count, 1);
    repeat (6) cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcie_status_led.md
PCIE_STATUS_LED -- requirements
Module: pcie_status_led

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of each error event counter.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 25000000: number of cycles an error LED stays lit after its last event (>=1).
REQ-003 SHALL have parameter HEARTBEAT_HALF, default 125000000: half-period of the heartbeat LED, in cycles (>=1).
REQ-004 SHALL have port clk, input, 1: the single clock for all logic, 250 MHz.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port status_error_cor, input, 1: correctable PCIe error indication; each cycle it is high counts as one event.
REQ-007 SHALL have port status_error_uncor, input, 1: uncorrectable PCIe error indication; each cycle it is high counts as one event.
REQ-008 SHALL have port clear, input, 1: single-cycle request to zero both counters and the sticky flag.
REQ-009 SHALL have port err_cor_count, output, COUNT_WIDTH: saturating count of correctable error events.
REQ-010 SHALL have port err_uncor_count, output, COUNT_WIDTH: saturating count of uncorrectable error events.
REQ-011 SHALL have port err_uncor_sticky, output, 1: latched flag meaning at least one uncorrectable error has occurred since reset or the last clear.
REQ-012 SHALL have port user_led_g, output, 2: bit 0 is the heartbeat; bit 1 indicates healthy, i.e. not err_uncor_sticky.
REQ-013 SHALL have port user_led_r, output, 1: lit while err_uncor_sticky is set.
REQ-014 SHALL have port front_led, output, 2: bit 0 is the stretched correctable activity; bit 1 is the stretched uncorrectable activity.

Function
REQ-015 Every output SHALL be registered and SHALL change only on a clk rising edge, except for asynchronous reset.
REQ-016 Each counter SHALL increment by 1 in the cycle after its status input is sampled high.
REQ-017 Each counter SHALL saturate at 2^COUNT_WIDTH-1; it SHALL neither wrap nor change when an event occurs at full count.
REQ-018 When clear is sampled high, each counter SHALL load 0 on the next edge.
REQ-019 If clear and an event coincide in the same cycle, the affected counter SHALL load 1; the event is not lost.
REQ-020 err_uncor_sticky SHALL set on the edge after status_error_uncor is sampled high.
REQ-021 err_uncor_sticky SHALL clear on the edge after clear is sampled high, unless status_error_uncor is high in the same cycle, in which case it SHALL remain set.
REQ-022 There SHALL be one stretcher per error input, each a two-state FSM with states IDLE and ACTIVE plus a down-counter of width $clog2(STRETCH_CYCLES+1).
REQ-023 In a stretcher, an event sampled in either state SHALL load the down-counter with STRETCH_CYCLES and enter ACTIVE; a new event in ACTIVE retriggers the full interval.
REQ-024 In ACTIVE with no event, the stretcher SHALL decrement its counter; when the counter reaches 1 it SHALL return to IDLE.
REQ-025 front_led[n] SHALL equal 1 exactly while its stretcher is in ACTIVE: it rises 1 cycle after the first event and stays high for STRETCH_CYCLES cycles after the last event.
REQ-026 The stretchers SHALL be unaffected by clear.
REQ-027 The heartbeat prescaler SHALL count 0 to HEARTBEAT_HALF-1, wrap to 0, and toggle user_led_g[0] on the wrap edge, giving a period of 2*HEARTBEAT_HALF cycles.
REQ-028 The heartbeat SHALL free-run and SHALL be unaffected by clear and by error events.
REQ-029 Events on both inputs in the same cycle SHALL be processed independently, with no priority or loss.

Reset
REQ-030 While rst_n is low, all counters and prescalers SHALL be 0, both stretchers SHALL be IDLE, err_uncor_sticky and user_led_g[0] SHALL be 0, and user_led_g[1] SHALL be 1.
REQ-031 rst_n asserting mid-operation SHALL immediately force the REQ-030 values without waiting for a clk edge.
REQ-032 After reset release, the first event SHALL be sampled on the first rising edge at which rst_n is high.

Verification
Run with COUNT_WIDTH=4, STRETCH_CYCLES=4, HEARTBEAT_HALF=8.
REQ-033 The bench SHALL cover: 3 single-cycle cor pulses -> err_cor_count=3; front_led[0] high 1 cycle after the first pulse and low exactly 4 cycles after the last.
REQ-034 The bench SHALL cover: cor held high for 20 cycles -> count saturates at 15 and stays 15; front_led[0] stays high.
REQ-035 The bench SHALL cover: 1 uncor pulse -> err_uncor_count=1, sticky=1, user_led_r=1, user_led_g[1]=0; then clear -> count=0, sticky=0, front_led[1] still finishes its 4-cycle stretch.
REQ-036 The bench SHALL cover: clear coinciding with uncor at count=5 -> err_uncor_count=1 and sticky remains 1.
REQ-037 The bench SHALL cover: free run from reset -> user_led_g[0] toggles every 8 cycles, i.e. period 16.
REQ-038 The bench SHALL cover: rst_n driven low between clock edges while front_led and the counts are nonzero -> all outputs take the REQ-030 values immediately.
